// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if
//
// Purpose: bundles every handshake and strobe signal between the control unit,
// the multiplier/divider units and the multiply/divide sequencer.
//
// Signals:
//   op_valid, op_sel          request and operation select (0 = mult, 1 = div)
//   op_ready                  sequencer can accept a request
//   mult_init, div_init       one-cycle start pulses to the units
//   mult_stop, div_stop       done strobes from the units
//   div_zero                  divide-by-zero flag from the divider
//   hilo_sel                  High/Low mux select (0 = mult, 1 = div)
//   high_load, low_load       High/Low register load enables
//   busy, done                status and successful-completion pulse
//   div0_exc, timeout_exc     abort pulses
//
// Modports:
//   master  the environment side (control unit plus the arithmetic units)
//   slave   the sequencer itself
interface muldiv_sequencer_if;
  logic op_valid;
  logic op_sel;
  logic op_ready;
  logic mult_init;
  logic mult_stop;
  logic div_init;
  logic div_stop;
  logic div_zero;
  logic hilo_sel;
  logic high_load;
  logic low_load;
  logic busy;
  logic done;
  logic div0_exc;
  logic timeout_exc;

  modport master (
    output op_valid, op_sel, mult_stop, div_stop, div_zero,
    input  op_ready, mult_init, div_init, hilo_sel, high_load, low_load,
           busy, done, div0_exc, timeout_exc
  );

  modport slave (
    input  op_valid, op_sel, mult_stop, div_stop, div_zero,
    output op_ready, mult_init, div_init, hilo_sel, high_load, low_load,
           busy, done, div0_exc, timeout_exc
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//
// Purpose: sequences one multiply or divide operation at a time. A request is
// accepted in IDLE, the selected unit gets a one-cycle start pulse, then the
// sequencer waits for that unit's stop strobe and either loads the High/Low
// registers (done) or aborts with an exception pulse.
//
// Ports:
//   clk     sole clock, rising edge
//   reset   asynchronous, active-low reset
//   bus     muldiv_sequencer_if.slave, all handshake/strobe signals
//
// Parameters:
//   TIMEOUT_CYCLES  maximum WAIT cycles before the watchdog aborts
//   CNT_W           watchdog counter width, needs 2**CNT_W > TIMEOUT_CYCLES
//
// Configuration:
//   MULDIV_SEQ_TIMEOUT_EN  when defined, builds the watchdog counter and the
//                          timeout abort; when undefined WAIT waits forever
//                          and timeout_exc is tied to 0.
module muldiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 48,
  parameter int CNT_W          = 6
) (
  input  logic                clk,
  input  logic                reset,
  muldiv_sequencer_if.slave   bus
);

  if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_cnt_w_check
    $error("muldiv_sequencer: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    EXC   = 3'd4
  } state_t;

  state_t state;
  state_t state_next;
  logic   op_reg;
  logic   op_next;
  logic   sel_stop;
  logic   cnt_expired;

  // Only the unit that was started may end the operation.
  assign sel_stop = op_reg ? bus.div_stop : bus.mult_stop;

  // State and latched operation register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      op_reg <= 1'b0;
    end else begin
      state  <= state_next;
      op_reg <= op_next;
    end
  end

`ifdef MULDIV_SEQ_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  logic             to_cause;

  // Watchdog: cleared in START, counts WAIT cycles and saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state == START) begin
      cnt <= '0;
    end else if (state == WAIT && cnt != CNT_W'(TIMEOUT_CYCLES)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign cnt_expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Remembers why WAIT was left towards EXC: a divide-by-zero has priority,
  // so any EXC entry without it must be the watchdog.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cause <= 1'b0;
    end else if (state == WAIT) begin
      to_cause <= ~(op_reg & bus.div_zero);
    end
  end

  assign bus.div0_exc    = (state == EXC) & ~to_cause;
  assign bus.timeout_exc = (state == EXC) & to_cause;
`else
  assign cnt_expired     = 1'b0;
  assign bus.div0_exc    = (state == EXC);
  assign bus.timeout_exc = 1'b0;
`endif

  // Next-state logic; WAIT exits in priority order div0, stop, watchdog.
  always_comb begin
    state_next = state;
    op_next    = op_reg;
    case (state)
      IDLE: begin
        if (bus.op_valid) begin
          op_next    = bus.op_sel;
          state_next = START;
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        if (op_reg && bus.div_zero) begin
          state_next = EXC;
        end else if (sel_stop) begin
          state_next = WRITE;
        end else if (cnt_expired) begin
          state_next = EXC;
        end
      end
      WRITE:   state_next = IDLE;
      EXC:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // op_ready is gated by reset so it reads 0 while reset is held, even though
  // the state register already sits in IDLE.
  assign bus.op_ready  = (state == IDLE) & reset;
  assign bus.busy      = (state != IDLE);
  assign bus.mult_init = (state == START) & ~op_reg;
  assign bus.div_init  = (state == START) & op_reg;
  assign bus.hilo_sel  = (state != IDLE) & op_reg;
  assign bus.high_load = (state == WRITE);
  assign bus.low_load  = (state == WRITE);
  assign bus.done      = (state == WRITE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//
// Purpose: self-checking bench for muldiv_sequencer. A transaction-level model
// (request age and termination cause) predicts every output each cycle; a
// handful of literal latency/count checks pin the model itself. Honours
// MULDIV_SEQ_TIMEOUT_EN the same way the design does.
module tb_muldiv_sequencer;
  localparam int TimeoutCycles = 48;
`ifdef MULDIV_SEQ_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  muldiv_sequencer_if bus();

  muldiv_sequencer #(.TIMEOUT_CYCLES(TimeoutCycles), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: active request, its op, its age (0 = start cycle, j+1 = WAIT cycle j)
  // and termination (0 none, 1 write, 2 div0, 3 timeout) for the current cycle.
  bit m_active = 1'b0;
  bit m_op     = 1'b0;
  int m_age    = 0;
  int m_term   = 0;
  int acc_cnt  = 0;
  int last_acc_cyc = -1;

  int done_cnt = 0, mult_init_cnt = 0, div0_cnt = 0, to_cnt = 0;
  int last_done_cyc = -1, last_to_cyc = -1;

  logic [9:0] act_v, exp_v;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 1'b0;
      m_term   = 0;
      m_age    = 0;
      m_op     = 1'b0;
    end else if (m_term != 0) begin
      m_active = 1'b0;
      m_term   = 0;
    end else if (!m_active) begin
      if (bus.op_valid) begin
        m_active     = 1'b1;
        m_op         = bus.op_sel;
        m_age        = 0;
        acc_cnt      = acc_cnt + 1;
        last_acc_cyc = cyc;
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else begin
      if (m_op && bus.div_zero)                               m_term = 2;
      else if (m_op ? bus.div_stop : bus.mult_stop)           m_term = 1;
      else if (ToEn && (m_age - 1) == TimeoutCycles - 1)      m_term = 3;
      else                                                    m_age  = m_age + 1;
    end
  end

  function automatic logic [9:0] expected_outputs();
    logic [9:0] e;
    e[9] = reset && !m_active;
    e[8] = m_active;
    e[7] = m_active && m_age == 0 && !m_op;
    e[6] = m_active && m_age == 0 && m_op;
    e[5] = m_active && m_op;
    e[4] = (m_term == 1);
    e[3] = (m_term == 1);
    e[2] = (m_term == 1);
    e[1] = (m_term == 2);
    e[0] = (m_term == 3);
    return e;
  endfunction

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    act_v = {bus.op_ready, bus.busy, bus.mult_init, bus.div_init, bus.hilo_sel,
             bus.high_load, bus.low_load, bus.done, bus.div0_exc, bus.timeout_exc};
    exp_v = expected_outputs();
    tests = tests + 1;
    if (act_v !== exp_v) begin
      fails = fails + 1;
      $display("[TB] FAIL cycle_check cyc=%0d got=%b expected=%b (op_ready busy mult_init div_init hilo_sel high_load low_load done div0_exc timeout_exc)",
               cyc, act_v, exp_v);
    end
    if (bus.done === 1'b1) begin
      done_cnt      = done_cnt + 1;
      last_done_cyc = cyc;
    end
    if (bus.mult_init === 1'b1) mult_init_cnt = mult_init_cnt + 1;
    if (bus.div0_exc === 1'b1) div0_cnt = div0_cnt + 1;
    if (bus.timeout_exc === 1'b1) begin
      to_cnt      = to_cnt + 1;
      last_to_cyc = cyc;
    end
  end

  task automatic check_output(input string name, input int actual, input int expected_v);
    tests = tests + 1;
    if (actual !== expected_v) begin
      fails = fails + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    bus.op_valid  = 1'b0;
    bus.op_sel    = 1'b0;
    bus.mult_stop = 1'b0;
    bus.div_stop  = 1'b0;
    bus.div_zero  = 1'b0;
  endtask

  // Called in an IDLE cycle; the stop strobe (and optional div_zero) is
  // raised in WAIT cycle k. Returns in the IDLE cycle after WRITE/EXC.
  task automatic apply_stimulus(input bit op, input int k, input bit zero);
    bus.op_valid = 1'b1;
    bus.op_sel   = op;
    tick();
    bus.op_valid = 1'b0;
    tick();
    repeat (k) tick();
    bus.div_zero = zero;
    if (op) bus.div_stop = 1'b1;
    else    bus.mult_stop = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

  int base_a, base_b, base_c;
  bit cur;
  int k;

  initial begin
    clear_inputs();
    reset = 1'b0;
    repeat (3) tick();
    check_output("reset_op_ready", int'(bus.op_ready), 0);
    check_output("reset_busy", int'(bus.busy), 0);
    reset = 1'b1;
    #1;
    check_output("op_ready_after_release", int'(bus.op_ready), 1);
    tick();

    // Multiply with stop 32 cycles into WAIT.
    base_a = mult_init_cnt;
    base_b = done_cnt;
    apply_stimulus(1'b0, 32, 1'b0);
    check_output("mult_latency", last_done_cyc - last_acc_cyc, 35);
    check_output("mult_init_pulses", mult_init_cnt - base_a, 1);
    check_output("mult_done_pulses", done_cnt - base_b, 1);

    // Divide by zero together with div_stop in WAIT cycle 3.
    base_a = div0_cnt;
    base_b = done_cnt;
    apply_stimulus(1'b1, 3, 1'b1);
    check_output("div0_pulses", div0_cnt - base_a, 1);
    check_output("div0_no_done", done_cnt - base_b, 0);
    check_output("div0_idle_after", int'(bus.busy), 0);

    // Requests and a foreign stop strobe during a divide are ignored.
    base_a = mult_init_cnt;
    base_b = done_cnt;
    base_c = acc_cnt;
    bus.op_valid = 1'b1;
    bus.op_sel   = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    repeat (3) tick();
    bus.op_valid  = 1'b1;
    bus.op_sel    = 1'b0;
    bus.mult_stop = 1'b1;
    tick();
    clear_inputs();
    check_output("busy_hilo_held", int'(bus.hilo_sel), 1);
    repeat (3) tick();
    bus.div_stop = 1'b1;
    tick();
    clear_inputs();
    tick();
    check_output("busy_no_mult_init", mult_init_cnt - base_a, 0);
    check_output("busy_one_done", done_cnt - base_b, 1);
    check_output("busy_one_accept", acc_cnt - base_c, 1);

    // Watchdog.
    base_a = to_cnt;
    bus.op_valid = 1'b1;
    bus.op_sel   = 1'b0;
    tick();
    bus.op_valid = 1'b0;
`ifdef MULDIV_SEQ_TIMEOUT_EN
    repeat (60) tick();
    check_output("timeout_pulses", to_cnt - base_a, 1);
    check_output("timeout_latency", last_to_cyc - last_acc_cyc, 50);
`else
    repeat (200) tick();
    check_output("no_timeout_busy", int'(bus.busy), 1);
    check_output("no_timeout_pulses", to_cnt - base_a, 0);
    bus.mult_stop = 1'b1;
    tick();
    clear_inputs();
    tick();
`endif

    // Reset in WAIT cycle 10 aborts silently.
    base_b = done_cnt;
    bus.op_valid = 1'b1;
    bus.op_sel   = 1'b0;
    tick();
    bus.op_valid = 1'b0;
    repeat (11) tick();
    reset = 1'b0;
    #1;
    check_output("reset_outputs_zero",
                 int'({bus.op_ready, bus.busy, bus.mult_init, bus.div_init, bus.hilo_sel,
                       bus.high_load, bus.low_load, bus.done, bus.div0_exc, bus.timeout_exc}), 0);
    tick();
    reset = 1'b1;
    #1;
    check_output("reset_release_ready", int'(bus.op_ready), 1);
    tick();
    check_output("reset_abort_no_done", done_cnt - base_b, 0);
    apply_stimulus(1'b0, 5, 1'b0);
    check_output("mult_after_reset_done", done_cnt - base_b, 1);

    // Back-to-back with op_valid held high and alternating op_sel.
    base_c = acc_cnt;
    cur = 1'b0;
    bus.op_valid = 1'b1;
    bus.op_sel   = cur;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.op_sel = ~cur;
      tick();
      k = $urandom_range(0, 4);
      repeat (k) tick();
      if (cur) bus.div_stop = 1'b1;
      else     bus.mult_stop = 1'b1;
      tick();
      bus.div_stop  = 1'b0;
      bus.mult_stop = 1'b0;
      cur = ~cur;
      tick();
    end
    bus.op_valid = 1'b0;
    tick();
    check_output("back_to_back_accepts", acc_cnt - base_c, 6);

    // Randomized traffic, frequent then rare strobes, occasional resets.
    for (int i = 0; i < 700; i++) begin
      int sp;
      sp = (i < 400) ? 9 : 70;
      bus.op_valid  = ($urandom_range(0, 3) == 0);
      bus.op_sel    = 1'($urandom_range(0, 1));
      bus.mult_stop = ($urandom_range(0, sp) == 0);
      bus.div_stop  = ($urandom_range(0, sp) == 0);
      bus.div_zero  = ($urandom_range(0, 3 * sp) == 0);
      reset         = ($urandom_range(0, 199) != 0);
      tick();
    end
    clear_inputs();
    reset = 1'b1;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
